// File: rtl/l2_request_responder.sv
// l2_request_responder: in-order L2 responder for I/D L1 requests with fixed access latency and request statistics.
module l2_request_responder #(
    parameter int ADDR_BITS  = 26,
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [ADDR_BITS-1:0]          iaddr_from_L1,
    input  logic [1:0]                    icommand_from_L1,
    input  logic [ADDR_BITS-1:0]          daddr_from_L1,
    input  logic [1:0]                    dcommand_from_L1,
    output logic                          resp_valid,
    output logic [ADDR_BITS-1:0]          resp_addr,
    output logic [1:0]                    resp_cmd,
    output logic                          resp_src,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [31:0]                   read_count,
    output logic [31:0]                   write_count,
    output logic [31:0]                   rfo_count,
    output logic [31:0]                   drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] q_addr [FIFO_DEPTH];
    logic [1:0]           q_cmd  [FIFO_DEPTH];
    logic                 q_src  [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr, d_ptr;
    logic [TW-1:0]        cnt;
    logic [ADDR_BITS-1:0] svc_addr;
    logic [1:0]           svc_cmd;
    logic                 svc_src;
    logic                 i_req, d_req, pop, i_acc, d_acc;
    logic [CW-1:0]        free;

    assign i_req = icommand_from_L1 != 2'b00;
    assign d_req = dcommand_from_L1 != 2'b00;
    assign pop   = occupancy != '0 && (state == IDLE || state == RESPOND);
    // the pop frees its slot before this edge's pushes are considered
    assign free  = CW'(FIFO_DEPTH) - occupancy + CW'(pop);
    assign i_acc = i_req && free != '0;
    assign d_acc = d_req && free > CW'(i_acc);
    assign d_ptr = wr_ptr + PW'(i_acc);
    assign busy  = state != IDLE || occupancy != '0;

    always_ff @(posedge Clock) begin
        if (!Reset && i_acc) begin
            q_addr[wr_ptr] <= iaddr_from_L1;
            q_cmd[wr_ptr]  <= icommand_from_L1;
            q_src[wr_ptr]  <= 1'b0;
        end
        if (!Reset && d_acc) begin
            q_addr[d_ptr] <= daddr_from_L1;
            q_cmd[d_ptr]  <= dcommand_from_L1;
            q_src[d_ptr]  <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            cnt         <= '0;
            svc_addr    <= '0;
            svc_cmd     <= '0;
            svc_src     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_addr   <= '0;
            resp_cmd    <= '0;
            resp_src    <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
            rfo_count   <= '0;
            drop_count  <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(i_acc) + PW'(d_acc);
            rd_ptr      <= rd_ptr + PW'(pop);
            occupancy   <= occupancy + CW'(i_acc) + CW'(d_acc) - CW'(pop);
            read_count  <= read_count + 32'(i_acc && icommand_from_L1 == 2'b01)
                                      + 32'(d_acc && dcommand_from_L1 == 2'b01);
            write_count <= write_count + 32'(i_acc && icommand_from_L1 == 2'b10)
                                       + 32'(d_acc && dcommand_from_L1 == 2'b10);
            rfo_count   <= rfo_count + 32'(i_acc && icommand_from_L1 == 2'b11)
                                     + 32'(d_acc && dcommand_from_L1 == 2'b11);
            drop_count  <= drop_count + 32'(i_req && !i_acc) + 32'(d_req && !d_acc);
            resp_valid  <= 1'b0;
            if (pop) begin
                svc_addr <= q_addr[rd_ptr];
                svc_cmd  <= q_cmd[rd_ptr];
                svc_src  <= q_src[rd_ptr];
                cnt      <= TW'(LATENCY - 1);
                state    <= BUSY;
            end else if (state == BUSY) begin
                if (cnt == '0) begin
                    state      <= RESPOND;
                    resp_valid <= 1'b1;
                    resp_addr  <= svc_addr;
                    resp_cmd   <= svc_cmd;
                    resp_src   <= svc_src;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == RESPOND) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_l2_request_responder.sv
// tb_l2_request_responder: directed and randomized checks of l2_request_responder against a timeline model.
module tb_l2_request_responder;
    localparam int AB = 26;
    localparam int DEPTH = 4;
    localparam int LAT = 4;

    typedef struct {
        logic [AB-1:0] a;
        logic [1:0]    c;
        logic          s;
    } req_t;

    logic          Clock, Reset;
    logic [AB-1:0] iaddr_from_L1, daddr_from_L1;
    logic [1:0]    icommand_from_L1, dcommand_from_L1;
    logic          resp_valid, resp_src, busy;
    logic [AB-1:0] resp_addr;
    logic [1:0]    resp_cmd;
    logic [2:0]    occupancy;
    logic [31:0]   read_count, write_count, rfo_count, drop_count;

    l2_request_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .Clock(Clock), .Reset(Reset),
        .iaddr_from_L1(iaddr_from_L1), .icommand_from_L1(icommand_from_L1),
        .daddr_from_L1(daddr_from_L1), .dcommand_from_L1(dcommand_from_L1),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_cmd(resp_cmd), .resp_src(resp_src),
        .busy(busy), .occupancy(occupancy),
        .read_count(read_count), .write_count(write_count), .rfo_count(rfo_count), .drop_count(drop_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: each popped request completes exactly LAT edges after its pop, and the
    // server can pop again on any edge after the previous completion edge.
    req_t        q[$];
    req_t        cur, nr;
    longint      e = 0;
    longint      done = -1;
    bit          m_valid;
    req_t        m_resp;
    int unsigned m_cnt[4];
    int unsigned m_drop;

    function automatic void m_accept(input logic [1:0] c, input logic [AB-1:0] a, input logic s);
        if (c == 2'b00) return;
        if (q.size() < DEPTH) begin
            nr.a = a; nr.c = c; nr.s = s;
            q.push_back(nr);
            m_cnt[c]++;
        end else begin
            m_drop++;
        end
    endfunction

    always @(posedge Clock) begin
        e++;
        if (Reset) begin
            q.delete();
            done = -1;
            m_valid = 1'b0;
            m_resp.a = '0; m_resp.c = '0; m_resp.s = 1'b0;
            m_cnt = '{0, 0, 0, 0};
            m_drop = 0;
        end else begin
            if (q.size() > 0 && e > done) begin
                cur = q.pop_front();
                done = e + LAT;
            end
            m_accept(icommand_from_L1, iaddr_from_L1, 1'b0);
            m_accept(dcommand_from_L1, daddr_from_L1, 1'b1);
            m_valid = (e == done);
            if (m_valid) m_resp = cur;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("resp_valid", resp_valid, m_valid);
            chk("resp_addr", resp_addr, m_resp.a);
            chk("resp_cmd", resp_cmd, m_resp.c);
            chk("resp_src", resp_src, m_resp.s);
            chk("occupancy", occupancy, q.size());
            chk("busy", busy, q.size() > 0 || e <= done);
            chk("read_count", read_count, m_cnt[1]);
            chk("write_count", write_count, m_cnt[2]);
            chk("rfo_count", rfo_count, m_cnt[3]);
            chk("drop_count", drop_count, m_drop);
        end
    end

    task automatic idle_inputs(input bit zaddr);
        icommand_from_L1 = 2'b00;
        dcommand_from_L1 = 2'b00;
        iaddr_from_L1 = zaddr ? 'z : '0;
        daddr_from_L1 = zaddr ? 'z : '0;
    endtask

    task automatic drive(input logic [1:0] ic, input logic [AB-1:0] ia, input logic [1:0] dc, input logic [AB-1:0] da);
        icommand_from_L1 = ic;
        iaddr_from_L1 = ic != 2'b00 ? ia : 'z;
        dcommand_from_L1 = dc;
        daddr_from_L1 = dc != 2'b00 ? da : 'z;
        @(negedge Clock);
        idle_inputs(1'b1);
    endtask

    task automatic do_reset();
        idle_inputs(1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic wait_resp(input string nm, output int n);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (!resp_valid) chk({nm, "_timeout"}, 0, 1);
    endtask

    int n;
    int unsigned d0;
    logic [AB-1:0] t3_addr [5];

    initial begin
        idle_inputs(1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_occ", occupancy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", resp_addr, 0);

        // single read: response pulse after edge E0+5
        do_reset();
        drive(2'b01, 26'h0ABCDEF, 2'b00, '0);
        wait_resp("t1", n);
        chk("t1_latency", n, 5);
        chk("t1_addr", resp_addr, 26'h0ABCDEF);
        chk("t1_cmd", resp_cmd, 2'b01);
        chk("t1_src", resp_src, 1'b0);
        chk("t1_reads", read_count, 1);
        @(negedge Clock);
        chk("t1_pulse_len", resp_valid, 0);

        // simultaneous I read and D RFO
        do_reset();
        drive(2'b01, 26'h1, 2'b11, 26'h2);
        wait_resp("t2a", n);
        chk("t2_first_addr", resp_addr, 26'h1);
        chk("t2_first_src", resp_src, 1'b0);
        @(negedge Clock);
        wait_resp("t2b", n);
        chk("t2_gap", n + 1, 5);
        chk("t2_second_addr", resp_addr, 26'h2);
        chk("t2_second_cmd", resp_cmd, 2'b11);
        chk("t2_counts", {read_count[7:0], rfo_count[7:0]}, 16'h0101);

        // six D writes while the FSM is busy
        do_reset();
        for (int i = 0; i < 6; i++)
            drive(i == 0 ? 2'b01 : 2'b00, 26'h100, 2'b10, 26'h200 + AB'(i));
        chk("t3_drops", drop_count, 2);
        chk("t3_writes", write_count, 4);
        t3_addr = '{26'h100, 26'h200, 26'h201, 26'h202, 26'h203};
        for (int i = 0; i < 5; i++) begin
            wait_resp("t3", n);
            chk("t3_order", resp_addr, t3_addr[i]);
            @(negedge Clock);
        end

        // NOPs with floating addresses
        do_reset();
        for (int i = 0; i < 20; i++) drive(2'b00, '0, 2'b00, '0);
        chk("t4_busy", busy, 0);
        chk("t4_counts", read_count | write_count | rfo_count | drop_count, 0);

        // reset in the middle of a service with two queued requests
        do_reset();
        drive(2'b01, 26'h10, 2'b01, 26'h11);
        drive(2'b00, '0, 2'b01, 26'h12);
        @(negedge Clock);
        @(negedge Clock);
        do_reset();
        chk("t5_occ", occupancy, 0);
        chk("t5_busy", busy, 0);
        chk("t5_reads", read_count, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            n += int'(resp_valid);
        end
        chk("t5_no_resp", n, 0);

        // full FIFO popping on the same edge as a new I read
        do_reset();
        drive(2'b01, 26'h20, 2'b10, 26'h21);
        drive(2'b01, 26'h22, 2'b10, 26'h23);
        drive(2'b00, '0, 2'b10, 26'h24);
        for (int i = 0; i < 3; i++) drive(2'b00, '0, 2'b00, '0);
        chk("t6_resp", resp_valid, 1);
        chk("t6_full", occupancy, 4);
        d0 = drop_count;
        drive(2'b01, 26'h25, 2'b00, '0);
        chk("t6_occ", occupancy, 4);
        chk("t6_drop_same", drop_count, d0);
        chk("t6_reads", read_count, 3);

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive($urandom_range(0, 2) == 0 ? 2'b01 : 2'b00, AB'($urandom),
                       $urandom_range(0, 1) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, AB'($urandom));
        end
        for (int i = 0; i < 40; i++) drive(2'b00, '0, 2'b00, '0);
        chk("drain_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
